vga_pixel_timing: RTL and testbench

Raster timing generator for the 640x480@60 VGA path. It scans horizontal and vertical counters and publishes `pixelX`/`pixelY` to the background and object drawing stages, which consume them directly. It also produces active-low sync and blanking for the DAC/connector. Sync and blank are also available through a programmable pipeline so they stay aligned with the registered RGB produced one or more cycles downstream.

---
 rtl/vga_pixel_timing.sv | 92 +++++++++
 tb/tb_vga_pixel_timing.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_timing.sv
// Raster timing generator: 11-bit h/v scan counters with registered sync/blank decode
// and a short clk-rate delay line that keeps sync/blank aligned with downstream RGB.
`timescale 1ns/1ps

module vga_pixel_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        pixelEnable,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        displayEn,
  output logic        startOfFrame,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        hSyncN_d,
  output logic        vSyncN_d,
  output logic        blankN_d
);

  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_nxt;
  logic [10:0] v_nxt;

  always_comb begin
    h_nxt = (pixelX == H_LAST) ? '0 : pixelX + 11'd1;
    v_nxt = pixelY;
    if (pixelX == H_LAST)
      v_nxt = (pixelY == V_LAST) ? '0 : pixelY + 11'd1;
  end

  // Decode from the next-state counts so every flag lines up with the pixelX/pixelY it describes.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX       <= H_LAST;
      pixelY       <= V_LAST;
      displayEn    <= 1'b0;
      startOfFrame <= 1'b0;
      hSyncN       <= 1'b1;
      vSyncN       <= 1'b1;
    end else if (pixelEnable) begin
      pixelX       <= h_nxt;
      pixelY       <= v_nxt;
      displayEn    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      startOfFrame <= (h_nxt == '0) && (v_nxt == '0);
      hSyncN       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vSyncN       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      assign hSyncN_d = hSyncN;
      assign vSyncN_d = vSyncN;
      assign blankN_d = displayEn;
    end else begin : g_delay
      // Each stage holds {hSyncN, vSyncN, displayEn}; shifts every clk regardless of pixelEnable.
      logic [2:0] dly_q [PIPE_DELAY];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++)
            dly_q[i] <= 3'b110;
        end else begin
          dly_q[0] <= {hSyncN, vSyncN, displayEn};
          for (int unsigned i = 1; i < PIPE_DELAY; i++)
            dly_q[i] <= dly_q[i-1];
        end
      end

      assign {hSyncN_d, vSyncN_d, blankN_d} = dly_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Directed bench: default 640x480 timing with a 2-stage sync pipeline, plus a
// shrunken raster (16x8 totals, no pipeline) so whole frames fit in a short run.
`timescale 1ns/1ps

module tb_vga_pixel_timing;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        pixelEnable = 1'b0;

  logic [10:0] pixelX, pixelY;
  logic        displayEn, startOfFrame, hSyncN, vSyncN, hSyncN_d, vSyncN_d, blankN_d;

  logic [10:0] s_pixelX, s_pixelY;
  logic        s_displayEn, s_startOfFrame, s_hSyncN, s_vSyncN, s_hSyncN_d, s_vSyncN_d, s_blankN_d;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  vga_pixel_timing #(.PIPE_DELAY(2)) dut (
    .clk(clk), .resetN(resetN), .pixelEnable(pixelEnable),
    .pixelX(pixelX), .pixelY(pixelY), .displayEn(displayEn), .startOfFrame(startOfFrame),
    .hSyncN(hSyncN), .vSyncN(vSyncN),
    .hSyncN_d(hSyncN_d), .vSyncN_d(vSyncN_d), .blankN_d(blankN_d)
  );

  vga_pixel_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(0)
  ) dut_small (
    .clk(clk), .resetN(resetN), .pixelEnable(pixelEnable),
    .pixelX(s_pixelX), .pixelY(s_pixelY), .displayEn(s_displayEn), .startOfFrame(s_startOfFrame),
    .hSyncN(s_hSyncN), .vSyncN(s_vSyncN),
    .hSyncN_d(s_hSyncN_d), .vSyncN_d(s_vSyncN_d), .blankN_d(s_blankN_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected undelayed hSyncN / displayEn of the default raster at position x (line visible);
  // x = -1 / -2 stand for the reset state seen by the pipeline before the first edge.
  function automatic logic exp_hs(input int x);
    return (x < 0) ? 1'b1 : !((x >= 656) && (x < 752));
  endfunction
  function automatic logic exp_de(input int x);
    return (x >= 0) && (x < 640);
  endfunction

  // Position during the 1,0,1,0 enable-toggle phase; -1 is its start (0,1), -2 the end of line 0.
  function automatic int gate_x(input int j);
    if (j == -2) return 799;
    if (j == -1) return 0;
    return (j / 2 + 1) % 800;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int bad, bad_pos, bad_dec, bad_pipe;
    int hs_low, hs_first, de_cnt, sof_cnt, vs_low, vs_first, s_sof_cnt;

    // Reset held
    repeat (3) @(negedge clk);
    check("rst_pixelX",    pixelX,       799);
    check("rst_pixelY",    pixelY,       524);
    check("rst_hSyncN",    hSyncN,       1);
    check("rst_vSyncN",    vSyncN,       1);
    check("rst_displayEn", displayEn,    0);
    check("rst_sof",       startOfFrame, 0);
    check("rst_blankN_d",  blankN_d,     0);
    check("rst_hSyncN_d",  hSyncN_d,     1);
    check("rst_vSyncN_d",  vSyncN_d,     1);

    // Release: first edge wraps (799,524) -> (0,0)
    resetN = 1'b1;
    pixelEnable = 1'b1;
    @(negedge clk);
    check("start_pixelX",    pixelX,       0);
    check("start_pixelY",    pixelY,       0);
    check("start_sof",       startOfFrame, 1);
    check("start_displayEn", displayEn,    1);
    check("start_blankN_d",  blankN_d,     0);

    // One full visible line at full rate
    bad = 0; hs_low = 0; hs_first = -1; de_cnt = 0; sof_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (pixelX !== 11'(i) || pixelY !== 11'd0) bad++;
      if (hSyncN_d !== exp_hs(i - 2) || blankN_d !== exp_de(i - 2) || vSyncN_d !== 1'b1) bad++;
      if (!hSyncN) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (displayEn) de_cnt++;
      if (startOfFrame) sof_cnt++;
      @(negedge clk);
    end
    check("line_scan_and_pipe2", bad,      0);
    check("hsync_width",         hs_low,   96);
    check("hsync_start_x",       hs_first, 656);
    check("display_width",       de_cnt,   640);
    check("sof_one_cycle",       sof_cnt,  1);
    check("line_period_x",       pixelX,   0);
    check("line_period_y",       pixelY,   1);

    // Enable toggling 1,0,1,0: every pixel held 2 clks, line takes 1600 clks; pipeline keeps clk rate
    bad = 0; bad_pipe = 0;
    for (int j = 0; j < 1600; j++) begin
      pixelEnable = (j % 2 == 0);
      @(negedge clk);
      if (pixelX !== 11'(gate_x(j)) || pixelY !== ((j / 2 + 1 >= 800) ? 11'd2 : 11'd1)) bad++;
      if (blankN_d !== exp_de(gate_x(j - 2)) || hSyncN_d !== exp_hs(gate_x(j - 2))) bad_pipe++;
    end
    check("gated_hold",      bad,      0);
    check("gated_pipe",      bad_pipe, 0);
    check("gated_period_x",  pixelX,   0);
    check("gated_period_y",  pixelY,   2);

    // Enable low for 50 clks: everything frozen at (0,2)
    pixelEnable = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pixelX !== 11'd0 || pixelY !== 11'd2 || displayEn !== 1'b1 || hSyncN !== 1'b1 ||
          vSyncN !== 1'b1 || startOfFrame !== 1'b0 || blankN_d !== 1'b1 || hSyncN_d !== 1'b1 ||
          vSyncN_d !== 1'b1) bad++;
    end
    check("freeze_50", bad, 0);

    // Advance to (300,2), then assert reset between edges
    pixelEnable = 1'b1;
    repeat (300) @(negedge clk);
    check("pre_reset_x", pixelX, 300);
    check("pre_reset_y", pixelY, 2);
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_x",       pixelX,    799);
    check("async_rst_y",       pixelY,    524);
    check("async_rst_de",      displayEn, 0);
    check("async_rst_blankN_d", blankN_d, 0);
    check("async_rst_hSyncN_d", hSyncN_d, 1);
    @(negedge clk);
    check("rst_hold_x", pixelX, 799);
    resetN = 1'b1;
    @(negedge clk);
    check("restart_x",   pixelX,       0);
    check("restart_y",   pixelY,       0);
    check("restart_sof", startOfFrame, 1);

    // Small raster, two frames from (0,0); PIPE_DELAY=0 outputs track in the same cycle
    bad_pos = 0; bad_dec = 0; bad_pipe = 0; vs_low = 0; vs_first = -1; s_sof_cnt = 0; sof_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      int ex, ey;
      logic e_de, e_hs, e_vs;
      ex = i % 16;
      ey = (i / 16) % 8;
      e_de = (ex < 8) && (ey < 4);
      e_hs = !((ex >= 10) && (ex < 13));
      e_vs = !((ey == 5) || (ey == 6));
      if (s_pixelX !== 11'(ex) || s_pixelY !== 11'(ey)) bad_pos++;
      if (s_displayEn !== e_de || s_hSyncN !== e_hs || s_vSyncN !== e_vs ||
          s_startOfFrame !== ((ex == 0) && (ey == 0))) bad_dec++;
      if (s_blankN_d !== e_de || s_hSyncN_d !== e_hs || s_vSyncN_d !== e_vs) bad_pipe++;
      if (!s_vSyncN) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if (s_startOfFrame) s_sof_cnt++;
      if (startOfFrame) sof_cnt++;
      if (i == 127) begin
        check("small_last_x", s_pixelX, 15);
        check("small_last_y", s_pixelY, 7);
      end
      @(negedge clk);
    end
    check("small_position",   bad_pos,   0);
    check("small_decode",     bad_dec,   0);
    check("small_pipe0",      bad_pipe,  0);
    check("small_vsync_len",  vs_low,    64);
    check("small_vsync_start", vs_first, 80);
    check("small_sof_count",  s_sof_cnt, 2);
    check("small_wrap_x",     s_pixelX,  0);
    check("small_wrap_y",     s_pixelY,  0);
    check("small_wrap_sof",   s_startOfFrame, 1);
    check("big_sof_count",    sof_cnt,   1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
